mul_accumulate_seq: RTL and testbench



---
 rtl/mul_acc_pkg.sv | 22 ++
 rtl/mul_tag_pipe.sv | 32 +++
 rtl/mul_accumulate_seq.sv | 98 +++++++++
 tb/tb_mul_accumulate_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_acc_pkg.sv
// Shared widths, FSM state encoding and the {vld, last} tag carried alongside multiplier operands.
// No logic; types and constants only.
// Not applicable: holds no flow-controlled state.
package mul_acc_pkg;

    localparam int WIDTH_DEF       = 32;
    localparam int MUL_LATENCY_DEF = 2;
    localparam int ACC_WIDTH_DEF   = 72;
    localparam int CNT_WIDTH_DEF   = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_DRAIN = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

endpackage

// File: rtl/mul_tag_pipe.sv
// Delays the {vld, last} tag so it lines up with the product leaving the multiplier.
// Latency: MUL_LATENCY cycles.
// No backpressure: shifts every cycle; async clear drops all in-flight tags.
module mul_tag_pipe
    import mul_acc_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_nxt,
    output tag_t tag_dly
);

    tag_t stage [MUL_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_nxt;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_dly = stage[MUL_LATENCY-1];

endmodule

// File: rtl/mul_accumulate_seq.sv
// Feeds operand pairs to an external multiplier and sums tagged products into one dot product per vector.
// Latency: last pair accepted in cycle t gives out_valid in cycle t+MUL_LATENCY+1.
// Backpressure: in_ready drops from the last pair until the result is taken; result held while out_ready is low.
module mul_accumulate_seq
    import mul_acc_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_last,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf
);

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 ovf;
    tag_t                 tag_nxt;
    tag_t                 tag_dly;
    logic                 accept;
    logic                 res_take;
    logic [ACC_WIDTH:0]   add_sum;

    assign in_ready  = (state == ST_RUN);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign res_take  = out_valid && out_ready;

    assign mul_a = in_a;
    assign mul_b = in_b;

    // The multiplier has no valid of its own; only tagged cycles carry a real product.
    assign tag_nxt.vld  = accept;
    assign tag_nxt.last = in_last;

    mul_tag_pipe #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_nxt (tag_nxt),
        .tag_dly (tag_dly)
    );

    // Extra MSB captures the carry out of the accumulator for the sticky overflow.
    assign add_sum = {1'b0, acc} + (ACC_WIDTH+1)'(mul_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (accept && in_last)           state <= ST_DRAIN;
                ST_DRAIN: if (tag_dly.vld && tag_dly.last) state <= ST_DONE;
                ST_DONE:  if (out_ready)                   state <= ST_RUN;
                default:                                   state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (res_take) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (tag_dly.vld) begin
            acc <= add_sum[ACC_WIDTH-1:0];
            cnt <= cnt + CNT_WIDTH'(1);
            if (add_sum[ACC_WIDTH]) begin
                ovf <= 1'b1;
            end
        end
    end

    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_mul_accumulate_seq.sv
// Drives a default-width instance and a 64-bit-accumulator instance with the same pairs,
// each behind its own two-stage multiplier model, and checks results against an exact-sum model.
module tb_mul_accumulate_seq;

    localparam int W  = 32;
    localparam int ML = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_last;
    logic          out_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;

    logic          in_ready_72, out_valid_72, out_ovf_72;
    logic [W-1:0]  mul_a_72, mul_b_72, ra_72, rb_72;
    logic [2*W-1:0] mul_y_72;
    logic [71:0]   out_sum_72;
    logic [15:0]   out_count_72;

    logic          in_ready_64, out_valid_64, out_ovf_64;
    logic [W-1:0]  mul_a_64, mul_b_64, ra_64, rb_64;
    logic [2*W-1:0] mul_y_64;
    logic [63:0]   out_sum_64;
    logic [15:0]   out_count_64;

    int            checks = 0;
    int            errors = 0;
    logic [127:0]  ref_sum;
    int            ref_cnt;
    int            lat;
    int            nel;

    always #5 clk = ~clk;

    mul_accumulate_seq #(.WIDTH(W), .MUL_LATENCY(ML), .ACC_WIDTH(72), .CNT_WIDTH(16)) dut72 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_72),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_a(mul_a_72), .mul_b(mul_b_72), .mul_y(mul_y_72),
        .out_valid(out_valid_72), .out_ready(out_ready),
        .out_sum(out_sum_72), .out_count(out_count_72), .out_ovf(out_ovf_72)
    );

    mul_accumulate_seq #(.WIDTH(W), .MUL_LATENCY(ML), .ACC_WIDTH(64), .CNT_WIDTH(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_64),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_a(mul_a_64), .mul_b(mul_b_64), .mul_y(mul_y_64),
        .out_valid(out_valid_64), .out_ready(out_ready),
        .out_sum(out_sum_64), .out_count(out_count_64), .out_ovf(out_ovf_64)
    );

    // Registered-in / registered-out multipliers with no reset.
    always @(posedge clk) begin
        ra_72 <= mul_a_72;  rb_72 <= mul_b_72;  mul_y_72 <= ra_72 * rb_72;
        ra_64 <= mul_a_64;  rb_64 <= mul_b_64;  mul_y_64 <= ra_64 * rb_64;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic last, input logic vld);
        in_valid = vld;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        if (vld) begin
            chk("in_ready_run_72", in_ready_72, 1'b1);
            chk("in_ready_run_64", in_ready_64, 1'b1);
            if (in_ready_72) begin
                ref_sum = ref_sum + 128'(a) * 128'(b);
                ref_cnt++;
            end
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid_72 && cycles < 50) begin
            tick();
            cycles++;
        end
        chk("done_timeout", out_valid_72, 1'b1);
    endtask

    task automatic check_fields(input string tag);
        chk({tag, "_vld64"}, out_valid_64, 1'b1);
        chk({tag, "_sum72"}, out_sum_72, ref_sum[71:0]);
        chk({tag, "_cnt72"}, out_count_72, 16'(ref_cnt));
        chk({tag, "_ovf72"}, out_ovf_72, ref_sum[127:72] != '0);
        chk({tag, "_sum64"}, out_sum_64, ref_sum[63:0]);
        chk({tag, "_cnt64"}, out_count_64, 16'(ref_cnt));
        chk({tag, "_ovf64"}, out_ovf_64, ref_sum[127:64] != '0);
    endtask

    task automatic take_result(input string tag);
        check_fields(tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_rdy_after"}, in_ready_72, 1'b1);
        chk({tag, "_vld_after"}, out_valid_72, 1'b0);
        chk({tag, "_sum_clear"}, out_sum_72, 72'd0);
        ref_sum = '0;
        ref_cnt = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        ref_sum   = '0;
        ref_cnt   = 0;
        tick();
        tick();
        chk("rst_in_ready", in_ready_72, 1'b1);
        chk("rst_out_valid", out_valid_72, 1'b0);
        chk("rst_sum", out_sum_72, 72'd0);
        chk("rst_count", out_count_72, 16'd0);
        chk("rst_ovf", out_ovf_72, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single element: ready drops next cycle, result MUL_LATENCY+1 after acceptance.
        send(32'd3, 32'd5, 1'b1, 1'b1);
        chk("single_rdy_low", in_ready_72, 1'b0);
        wait_done(lat);
        chk("single_latency", lat, ML);
        chk("single_sum15", out_sum_72, 72'd15);
        take_result("single");

        send(32'd1, 32'd2, 1'b0, 1'b1);
        send(32'd3, 32'd4, 1'b0, 1'b1);
        send(32'd5, 32'd6, 1'b0, 1'b1);
        send(32'd7, 32'd8, 1'b1, 1'b1);
        wait_done(lat);
        chk("vec4_sum100", out_sum_72, 72'd100);
        take_result("vec4");

        send(32'd2, 32'd2, 1'b0, 1'b1);
        send($urandom, $urandom, 1'b0, 1'b0);
        send($urandom, $urandom, 1'b0, 1'b0);
        send(32'd3, 32'd3, 1'b0, 1'b1);
        send(32'd4, 32'd4, 1'b1, 1'b1);
        wait_done(lat);
        chk("bubble_sum29", out_sum_72, 72'd29);
        take_result("bubble");

        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_done(lat);
        chk("ovf64_set", out_ovf_64, 1'b1);
        chk("ovf64_sum", out_sum_64, 64'hFFFF_FFFC_0000_0002);
        take_result("ovf");
        send(32'd1, 32'd1, 1'b1, 1'b1);
        wait_done(lat);
        chk("ovf64_cleared", out_ovf_64, 1'b0);
        take_result("after_ovf");

        send($urandom, $urandom, 1'b0, 1'b1);
        send($urandom, $urandom, 1'b1, 1'b1);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_vld", out_valid_72, 1'b1);
            chk("bp_rdy", in_ready_72, 1'b0);
            check_fields("bp");
        end
        take_result("bp");

        for (int v = 0; v < 6; v++) begin
            nel = $urandom_range(1, 8);
            for (int i = 0; i < nel; i++) begin
                if ($urandom_range(0, 2) == 0) send($urandom, $urandom, 1'b0, 1'b0);
                send($urandom, $urandom, i == nel - 1, 1'b1);
            end
            wait_done(lat);
            take_result("rand");
        end

        send(32'd9, 32'd9, 1'b0, 1'b1);
        send(32'd7, 32'd7, 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("mrst_in_ready", in_ready_72, 1'b1);
        chk("mrst_out_valid", out_valid_72, 1'b0);
        chk("mrst_sum", out_sum_72, 72'd0);
        chk("mrst_count", out_count_72, 16'd0);
        chk("mrst_ovf", out_ovf_72, 1'b0);
        tick();
        rst_n   = 1'b1;
        ref_sum = '0;
        ref_cnt = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("mrst_no_stale", out_sum_72, 72'd0);
        send(32'd2, 32'd3, 1'b1, 1'b1);
        wait_done(lat);
        chk("mrst_sum6", out_sum_72, 72'd6);
        take_result("mrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
